sb_msg_encoder: RTL and testbench
=================================

SB_MSG_ENCODER -- requirements
Module: sb_msg_encoder

Interface
REQ-001 Parameter buffer_size, default 4, sets the request FIFO depth in entries (legal range 2..16).
REQ-002 Parameter ack_timeout, default 255, sets the maximum number of cycles to wait for tx_ack_i per message (legal range 1..1023).
REQ-003 clk_100MHz  in  1  sideband message clock; all logic is on its rising edge.
REQ-004 reset_n  in  1  synchronous reset, active-low.
REQ-005 enable_i  in  1  permits the launch of new messages toward SB_TX.
REQ-006 req_valid_i  in  1  upstream message request valid.
REQ-007 req_ready_o  out  1  FIFO can accept a request.
REQ-008 req_opcode_i  in  5  message opcode.
REQ-009 req_msgcode_i  in  8  message code.
REQ-010 req_msgsubcode_i  in  8  message subcode.
REQ-011 req_msginfo_i  in  16  message info field.
REQ-012 req_srcid_i / req_dstid_i  in  3 each  source and destination IDs.
REQ-013 tx_data_o  out  64  assembled header to SB_TX data_i.
REQ-014 tx_valid_o  out  1  header valid; connects to SB_TX valid_i.
REQ-015 tx_ack_i  in  1  connects from SB_TX data_valid_ack_o.
REQ-016 timeout_o  out  1  one-cycle pulse when a message is dropped on ack timeout.
REQ-017 fifo_count_o  out  $clog2(buffer_size+1)  number of occupied FIFO entries.

Function
REQ-018 The header layout shall be as follows:
- [63] DP = 0
- [62] CP = XOR of [61:0]
- [61:59] dstid
- [58:56] 0
- [55:40] msginfo
- [39:32] msgsubcode
- [31:29] srcid
- [28:22] 0
- [21:14] msgcode
- [13:5] 0
- [4:0] opcode
REQ-019 The block shall assemble the header and parity when a request is pushed, and store the full 64-bit header in the FIFO.
REQ-020 req_ready_o shall be 1 only when fifo_count_o < buffer_size; a pop in the same cycle shall not raise ready.
REQ-021 A push shall occur in any cycle with req_valid_i && req_ready_o.
REQ-022 A simultaneous push and pop shall leave the count unchanged; FIFO pointers shall wrap modulo buffer_size.
REQ-023 The FSM shall have three states: IDLE, SEND, RELEASE.
REQ-024 IDLE -> SEND when enable_i=1 and the FIFO is not empty; tx_data_o shall be loaded from the FIFO head and tx_valid_o=1 from the next cycle.
REQ-025 In SEND, tx_valid_o and tx_data_o shall be held stable until tx_ack_i is sampled 1.
REQ-026 On ack in SEND, the block shall pop the FIFO, go to RELEASE, and deassert tx_valid_o in the next cycle.
REQ-027 In RELEASE, the block shall wait for tx_ack_i=0 and then go to IDLE; no new launch shall occur while ack is high.
REQ-028 The SEND wait counter shall clear on SEND entry and increment every cycle in SEND.
REQ-029 When the wait counter reaches ack_timeout without an ack, the block shall pop and discard the entry, pulse timeout_o for one cycle, drop tx_valid_o, and go to IDLE.
REQ-030 An ack arriving in the same cycle as a timeout shall win: the entry is popped as sent and timeout_o stays 0.
REQ-031 enable_i=0 shall block only IDLE->SEND; a message already in SEND or RELEASE shall complete normally.
REQ-032 Back-to-back messages shall have at least one cycle with tx_valid_o=0 between them.
REQ-033 tx_data_o shall hold its last value when tx_valid_o=0.

Reset
REQ-034 reset_n=0 sampled on a clock edge shall, on that edge, empty the FIFO, set the FSM to IDLE, and clear the wait counter.
REQ-035 Reset values shall be: tx_valid_o=0, tx_data_o=0, timeout_o=0, fifo_count_o=0, req_ready_o=1.
REQ-036 A reset during SEND shall abandon the message with no timeout_o pulse.

Verification
REQ-037 Single message: push opcode 5'h12, msgcode 8'h01, subcode 0, msginfo 0, srcid 3'b001, dstid 3'b100 -> tx_data_o = 64'h6000_0000_2000_4012 with tx_valid_o=1 until ack; count returns to 0.
REQ-038 Fill: push 5 requests with buffer_size=4 and enable_i=0 -> req_ready_o=0 after the 4th push, count=4, the 5th request is not accepted.
REQ-039 Ordering with SB_TX/SB_RX loopback: 3 queued messages -> SB_RX delivers them in push order, each with correct CP, and valid gaps of at least 1 cycle.
REQ-040 Timeout: hold tx_ack_i=0 with ack_timeout=8 -> timeout_o pulses once 8 cycles after tx_valid_o rises; count decrements by 1.
REQ-041 Ack held high for 5 cycles -> the next message launches only after ack falls.
REQ-042 Reset mid-SEND: assert reset_n=0 for 1 cycle -> tx_valid_o=0 and count=0 on the next cycle; no timeout_o pulse.

Source files
------------

// File: rtl/sb_msg_encoder.sv
// sb_msg_encoder: builds 64-bit sideband message headers from upstream
// requests, queues them in a small FIFO and hands them to SB_TX one at a
// time using a valid/ack handshake with an ack timeout.
//
// Ports:
//   clk_100MHz         sideband clock (rising edge)
//   reset_n            synchronous active-low reset
//   enable_i           permits launching new messages
//   req_valid_i/req_ready_o + req_* fields   upstream request push
//   tx_data_o/tx_valid_o/tx_ack_i            header handshake toward SB_TX
//   timeout_o          one-cycle pulse when a message is dropped on timeout
//   fifo_count_o       occupied FIFO entries
module sb_msg_encoder #(
  parameter int buffer_size = 4,
  parameter int ack_timeout = 255
) (
  input  logic                             clk_100MHz,
  input  logic                             reset_n,
  input  logic                             enable_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [4:0]                       req_opcode_i,
  input  logic [7:0]                       req_msgcode_i,
  input  logic [7:0]                       req_msgsubcode_i,
  input  logic [15:0]                      req_msginfo_i,
  input  logic [2:0]                       req_srcid_i,
  input  logic [2:0]                       req_dstid_i,
  output logic [63:0]                      tx_data_o,
  output logic                             tx_valid_o,
  input  logic                             tx_ack_i,
  output logic                             timeout_o,
  output logic [$clog2(buffer_size+1)-1:0] fifo_count_o
);

  localparam int CW = $clog2(buffer_size + 1);
  localparam int PW = $clog2(buffer_size);
  localparam int TW = $clog2(ack_timeout + 1);

  typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [63:0]      mem_q [buffer_size];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [63:0]      tx_data_q;
  logic [TW-1:0]    wait_cnt_q;
  logic             timeout_q;

  logic             push, pop, launch, acked, expire;
  logic [61:0]      hdr_body;
  logic [63:0]      hdr;

  // Header body without DP/CP; parity covers everything below CP.
  assign hdr_body = {req_dstid_i, 3'b0, req_msginfo_i, req_msgsubcode_i,
                     req_srcid_i, 7'b0, req_msgcode_i, 9'b0, req_opcode_i};
  assign hdr      = {1'b0, ^hdr_body, hdr_body};

  // Ready looks only at the registered count so a same-cycle pop cannot
  // create a combinational path from the ack into ready.
  assign req_ready_o  = (count_q < CW'(buffer_size));
  assign push         = req_valid_i && req_ready_o;
  assign fifo_count_o = count_q;
  assign tx_data_o    = tx_data_q;
  assign timeout_o    = timeout_q;

  // State register
  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i && count_q != '0) state_d = SEND;
      SEND:    if (tx_ack_i)                  state_d = RELEASE;
               else if (expire)               state_d = IDLE;
      RELEASE: if (!tx_ack_i)                 state_d = IDLE;
      default:                                state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    tx_valid_o = (state_q == SEND);
    launch     = (state_q == IDLE) && enable_i && (count_q != '0);
    acked      = (state_q == SEND) && tx_ack_i;
    // Counter sits at N-1 in the Nth SEND cycle; an ack in that cycle wins.
    expire     = (state_q == SEND) && !tx_ack_i &&
                 (wait_cnt_q == TW'(ack_timeout - 1));
    pop        = acked || expire;
  end

  // FIFO storage (no reset needed; validity is tracked by count/pointers)
  always_ff @(posedge clk_100MHz) begin
    if (push) mem_q[wr_ptr_q] <= hdr;
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(buffer_size - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(buffer_size - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // Head is copied out at launch so tx_data stays put through the
      // handshake and afterwards while valid is low.
      if (launch) tx_data_q <= mem_q[rd_ptr_q];
      if (launch)                wait_cnt_q <= '0;
      else if (state_q == SEND)  wait_cnt_q <= wait_cnt_q + 1'b1;
      timeout_q <= expire;
    end
  end

endmodule

// File: tb/tb_sb_msg_encoder.sv
module tb_sb_msg_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, rv, rr, vld, ack, tmo;
  logic [4:0]  op;
  logic [7:0]  mc, ms;
  logic [15:0] mi;
  logic [2:0]  sid, did;
  logic [63:0] data;
  logic [2:0]  cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sb_msg_encoder #(.buffer_size(4), .ack_timeout(8)) dut (
    .clk_100MHz(clk), .reset_n(rst_n), .enable_i(en),
    .req_valid_i(rv), .req_ready_o(rr), .req_opcode_i(op),
    .req_msgcode_i(mc), .req_msgsubcode_i(ms), .req_msginfo_i(mi),
    .req_srcid_i(sid), .req_dstid_i(did), .tx_data_o(data),
    .tx_valid_o(vld), .tx_ack_i(ack), .timeout_o(tmo), .fifo_count_o(cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] mk(input logic [4:0] o, input logic [7:0] c,
                                     input logic [7:0] s, input logic [15:0] f,
                                     input logic [2:0] sr, input logic [2:0] ds);
    logic [63:0] h;
    h = '0;
    h[61:59] = ds; h[55:40] = f; h[39:32] = s;
    h[31:29] = sr; h[21:14] = c; h[4:0] = o;
    h[62] = ^h[61:0];
    return h;
  endfunction

  task automatic push(input logic [4:0] o, input logic [7:0] c, input logic [7:0] s,
                      input logic [15:0] f, input logic [2:0] sr, input logic [2:0] ds);
    op = o; mc = c; ms = s; mi = f; sid = sr; did = ds; rv = 1'b1;
    step();
    rv = 1'b0;
  endtask

  // Bounded wait for tx_valid_o; expiry is reported as a failed check.
  task automatic wait_vld(input string tag);
    int k;
    k = 0;
    while (!vld && k < 20) begin
      step();
      k++;
    end
    if (!vld) chk({tag, "_vld_timeout"}, 0, 1);
  endtask

  logic [63:0] exp_q[$];
  logic [63:0] e;
  int          n;

  initial begin
    rst_n = 1'b0; en = 1'b0; rv = 1'b0; ack = 1'b0;
    op = '0; mc = '0; ms = '0; mi = '0; sid = '0; did = '0;
    step(2);
    chk("rst_vld", vld, 0);
    chk("rst_data", data, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_rdy", rr, 1);
    rst_n = 1'b1;
    step();

    // Single message, known header constant
    push(5'h12, 8'h01, 8'h00, 16'h0, 3'b001, 3'b100);
    chk("single_cnt1", cnt, 1);
    en = 1'b1;
    wait_vld("single");
    chk("single_data", data, 64'h6000_0000_2000_4012);
    step(3);
    chk("single_hold_vld", vld, 1);
    chk("single_hold_data", data, 64'h6000_0000_2000_4012);
    ack = 1'b1;
    step();
    chk("single_drop_vld", vld, 0);
    chk("single_cnt0", cnt, 0);
    ack = 1'b0;
    step(2);
    chk("single_data_kept", data, 64'h6000_0000_2000_4012);

    // Fill with enable low; 5th request must be refused
    en = 1'b0;
    exp_q.push_back(mk(5'h01, 8'hA5, 8'h3C, 16'hBEEF, 3'd7, 3'd2));
    exp_q.push_back(mk(5'h1F, 8'hFF, 8'hFF, 16'hFFFF, 3'd7, 3'd7));
    exp_q.push_back(mk(5'h00, 8'h00, 8'h00, 16'h0000, 3'd0, 3'd0));
    exp_q.push_back(mk(5'h0A, 8'h12, 8'h34, 16'h5678, 3'd5, 3'd3));
    push(5'h01, 8'hA5, 8'h3C, 16'hBEEF, 3'd7, 3'd2);
    push(5'h1F, 8'hFF, 8'hFF, 16'hFFFF, 3'd7, 3'd7);
    push(5'h00, 8'h00, 8'h00, 16'h0000, 3'd0, 3'd0);
    chk("fill_rdy3", rr, 1);
    push(5'h0A, 8'h12, 8'h34, 16'h5678, 3'd5, 3'd3);
    chk("fill_rdy4", rr, 0);
    chk("fill_cnt4", cnt, 4);
    push(5'h15, 8'h77, 8'h77, 16'h7777, 3'd1, 3'd1);
    chk("fill_cnt_5th", cnt, 4);
    chk("fill_no_launch", vld, 0);

    // Drain in order with a gap after every ack
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_vld($sformatf("ord%0d", i));
      e = exp_q.pop_front();
      chk($sformatf("ord%0d_data", i), data, e);
      chk($sformatf("ord%0d_cp", i), data[62], ^data[61:0]);
      step(2);
      ack = 1'b1;
      step();
      chk($sformatf("ord%0d_gap", i), vld, 0);
      ack = 1'b0;
      step();
      chk($sformatf("ord%0d_gap2", i), vld, 0);
    end
    chk("ord_cnt0", cnt, 0);

    // Ack held high blocks the next launch
    en = 1'b0;
    push(5'h03, 8'h10, 8'h20, 16'h1234, 3'd2, 3'd6);
    push(5'h04, 8'h11, 8'h21, 16'h4321, 3'd3, 3'd1);
    en = 1'b1;
    wait_vld("ackhi");
    ack = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (vld) n++;
    end
    chk("ackhi_no_launch", n, 0);
    ack = 1'b0;
    step();
    chk("ackhi_idle", vld, 0);
    step();
    chk("ackhi_relaunch", vld, 1);
    chk("ackhi_data2", data, mk(5'h04, 8'h11, 8'h21, 16'h4321, 3'd3, 3'd1));
    ack = 1'b1;
    step();
    ack = 1'b0;
    step(2);
    chk("ackhi_cnt0", cnt, 0);

    // Timeout: pulse 8 cycles after valid rises, one cycle wide
    push(5'h09, 8'h09, 8'h09, 16'h0909, 3'd1, 3'd2);
    wait_vld("tmo");
    n = 0;
    while (!tmo && n < 30) begin
      step();
      n++;
    end
    chk("tmo_delay", n, 8);
    chk("tmo_vld_low", vld, 0);
    chk("tmo_cnt0", cnt, 0);
    step();
    chk("tmo_one_cycle", tmo, 0);

    // Ack in the expiring cycle wins
    push(5'h0B, 8'h0B, 8'h0B, 16'h0B0B, 3'd3, 3'd4);
    wait_vld("race");
    step(7);
    chk("race_still_vld", vld, 1);
    ack = 1'b1;
    step();
    chk("race_tmo0", tmo, 0);
    chk("race_cnt0", cnt, 0);
    ack = 1'b0;
    step();
    chk("race_tmo0b", tmo, 0);

    // Reset in the middle of SEND
    en = 1'b0;
    push(5'h0C, 8'h0C, 8'h0C, 16'h0C0C, 3'd4, 3'd5);
    push(5'h0D, 8'h0D, 8'h0D, 16'h0D0D, 3'd5, 3'd6);
    en = 1'b1;
    wait_vld("rst");
    step(2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_vld", vld, 0);
    chk("rst_mid_cnt", cnt, 0);
    chk("rst_mid_tmo", tmo, 0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tmo || vld) n++;
    end
    chk("rst_mid_quiet", n, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
